// File: rtl/axi_mem_pkg.sv
// Shared constants and FSM state types for the AXI4 memory responder.
//   BURST_INCR  - only burst type served with real data
//   RESP_*      - B/R response codes
//   w_state_e / r_state_e - write / read channel FSM states
package axi_mem_pkg;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;
endpackage

// File: rtl/axi_mem_ram.sv
// Simple dual-port word RAM with per-byte write enable.
//   clk, rst              - clock; rst clears only the read data register
//   we_i/waddr_i/wbe_i/wdata_i - write port, byte lanes gated by wbe_i
//   re_i/rzero_i/raddr_i  - read launch; rzero_i loads zero instead of RAM data
//   rdata_o               - registered read data, held while re_i is low
// A write and a read to the same word in one cycle return the old word.
module axi_mem_ram #(
  parameter int DW    = 256,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [DW/8-1:0] wbe_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic            re_i,
  input  logic            rzero_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [DW-1:0]   rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < DW/8; b++) begin
        if (wbe_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= rzero_i ? '0 : mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 slave backed by an on-chip word RAM; one write and one read burst
// in flight, the two channels run independently.
//   clk, rst            - clock, asynchronous active-high reset
//   axi_aw*/axi_w*/axi_b* - write address, data and response channels
//   axi_ar*/axi_r*      - read address and data channels
//   lock/cache/prot     - accepted and ignored
// Only INCR bursts of full data width touch the RAM; anything else is
// fully handshaked and answered with SLVERR (reads return zero).
module axi_mem_slave
  import axi_mem_pkg::*;
#(
  parameter int C_AXI_ID_WIDTH   = 4,
  parameter int C_AXI_ADDR_WIDTH = 64,
  parameter int C_AXI_DATA_WIDTH = 256,
  parameter int MEM_DEPTH        = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [C_AXI_ID_WIDTH-1:0]     axi_awid,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic [7:0]                    axi_awlen,
  input  logic [2:0]                    axi_awsize,
  input  logic [1:0]                    axi_awburst,
  input  logic                          axi_awlock,
  input  logic [3:0]                    axi_awcache,
  input  logic [2:0]                    axi_awprot,
  input  logic                          axi_awvalid,
  output logic                          axi_awready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   axi_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                          axi_wlast,
  input  logic                          axi_wvalid,
  output logic                          axi_wready,
  output logic [C_AXI_ID_WIDTH-1:0]     axi_bid,
  output logic [1:0]                    axi_bresp,
  output logic                          axi_bvalid,
  input  logic                          axi_bready,
  input  logic [C_AXI_ID_WIDTH-1:0]     axi_arid,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_araddr,
  input  logic [7:0]                    axi_arlen,
  input  logic [2:0]                    axi_arsize,
  input  logic [1:0]                    axi_arburst,
  input  logic                          axi_arlock,
  input  logic [3:0]                    axi_arcache,
  input  logic [2:0]                    axi_arprot,
  input  logic                          axi_arvalid,
  output logic                          axi_arready,
  output logic [C_AXI_ID_WIDTH-1:0]     axi_rid,
  output logic [C_AXI_DATA_WIDTH-1:0]   axi_rdata,
  output logic [1:0]                    axi_rresp,
  output logic                          axi_rlast,
  output logic                          axi_rvalid,
  input  logic                          axi_rready
);
  localparam int         OFF       = $clog2(C_AXI_DATA_WIDTH/8);
  localparam int         IW        = $clog2(MEM_DEPTH);
  localparam logic [2:0] FULL_SIZE = 3'(OFF);

  // address bits outside the word index and the sideband fields are unused
  logic unused_ok;
  assign unused_ok = ^{axi_awaddr, axi_araddr, axi_awlock, axi_awcache, axi_awprot,
                       axi_arlock, axi_arcache, axi_arprot};

  logic aw_ok, ar_ok;
  assign aw_ok = (axi_awburst == BURST_INCR) && (axi_awsize == FULL_SIZE);
  assign ar_ok = (axi_arburst == BURST_INCR) && (axi_arsize == FULL_SIZE);

  // ---------------- write channel ----------------
  w_state_e                w_state_q, w_state_d;
  logic                    awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [C_AXI_ID_WIDTH-1:0] bid_q, bid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic [IW-1:0]           widx_q, widx_d;
  logic [8:0]              wcnt_q, wcnt_d, wbeat_q, wbeat_d;
  logic                    wok_q, wok_d, werr_q, werr_d;
  logic                    wfinal, ram_we;

  always_comb begin
    w_state_d = w_state_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    widx_d    = widx_q;
    wcnt_d    = wcnt_q;
    wbeat_d   = wbeat_q;
    wok_d     = wok_q;
    werr_d    = werr_q;
    wfinal    = (wbeat_q == wcnt_q - 9'd1);
    ram_we    = 1'b0;
    unique case (w_state_q)
      W_IDLE: if (axi_awvalid && awready_q) begin
        w_state_d = W_DATA;
        bid_d     = axi_awid;
        widx_d    = axi_awaddr[OFF +: IW];
        wcnt_d    = {1'b0, axi_awlen} + 9'd1;
        wbeat_d   = '0;
        wok_d     = aw_ok;
        werr_d    = 1'b0;
      end
      W_DATA: if (axi_wvalid && wready_q) begin
        ram_we  = wok_q;
        widx_d  = widx_q + IW'(1);
        wbeat_d = wbeat_q + 9'd1;
        // beat counter decides the end; a disagreeing wlast only flags an error
        werr_d  = werr_q | (axi_wlast != wfinal);
        if (wfinal) begin
          w_state_d = W_RESP;
          bresp_d   = (!wok_q || werr_d) ? RESP_SLVERR : RESP_OKAY;
        end
      end
      W_RESP: if (axi_bready && bvalid_q) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  // ---------------- read channel ----------------
  r_state_e                r_state_q, r_state_d;
  logic                    arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [C_AXI_ID_WIDTH-1:0] rid_q, rid_d;
  logic [1:0]              rresp_q, rresp_d;
  logic [IW-1:0]           ridx_q, ridx_d, ram_raddr;
  logic [8:0]              rbeat_q, rbeat_d;
  logic [7:0]              rlen_q, rlen_d;
  logic                    rok_q, rok_d, ram_re, ram_rzero;

  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    ridx_d    = ridx_q;
    rbeat_d   = rbeat_q;
    rlen_d    = rlen_q;
    rok_d     = rok_q;
    ram_re    = 1'b0;
    ram_raddr = ridx_q;
    ram_rzero = !rok_q;
    unique case (r_state_q)
      R_IDLE: if (axi_arvalid && arready_q) begin
        // beat 0 is fetched on the handshake so it is presented the next cycle
        r_state_d = R_DATA;
        rid_d     = axi_arid;
        rlen_d    = axi_arlen;
        rbeat_d   = '0;
        rok_d     = ar_ok;
        rresp_d   = ar_ok ? RESP_OKAY : RESP_SLVERR;
        rlast_d   = (axi_arlen == 8'd0);
        ram_re    = 1'b1;
        ram_raddr = axi_araddr[OFF +: IW];
        ram_rzero = !ar_ok;
        ridx_d    = axi_araddr[OFF +: IW] + IW'(1);
      end
      R_DATA: if (axi_rready && rvalid_q) begin
        if (rlast_q) begin
          r_state_d = R_IDLE;
          rlast_d   = 1'b0;
        end else begin
          ram_re  = 1'b1;
          ridx_d  = ridx_q + IW'(1);
          rbeat_d = rbeat_q + 9'd1;
          rlast_d = ((rbeat_q + 9'd1) == {1'b0, rlen_q});
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
      widx_q    <= '0;
      wcnt_q    <= '0;
      wbeat_q   <= '0;
      wok_q     <= 1'b0;
      werr_q    <= 1'b0;
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rresp_q   <= '0;
      ridx_q    <= '0;
      rbeat_q   <= '0;
      rlen_q    <= '0;
      rok_q     <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      widx_q    <= widx_d;
      wcnt_q    <= wcnt_d;
      wbeat_q   <= wbeat_d;
      wok_q     <= wok_d;
      werr_q    <= werr_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rresp_q   <= rresp_d;
      ridx_q    <= ridx_d;
      rbeat_q   <= rbeat_d;
      rlen_q    <= rlen_d;
      rok_q     <= rok_d;
    end
  end

  axi_mem_ram #(.DW(C_AXI_DATA_WIDTH), .DEPTH(MEM_DEPTH), .AW(IW)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (ram_we),
    .waddr_i (widx_q),
    .wbe_i   (axi_wstrb),
    .wdata_i (axi_wdata),
    .re_i    (ram_re),
    .rzero_i (ram_rzero),
    .raddr_i (ram_raddr),
    .rdata_o (axi_rdata)
  );

  assign axi_awready = awready_q;
  assign axi_wready  = wready_q;
  assign axi_bvalid  = bvalid_q;
  assign axi_bid     = bid_q;
  assign axi_bresp   = bresp_q;
  assign axi_arready = arready_q;
  assign axi_rvalid  = rvalid_q;
  assign axi_rlast   = rlast_q;
  assign axi_rid     = rid_q;
  assign axi_rresp   = rresp_q;
endmodule
